axis_allow_scheduler: RTL and testbench

AXIS_ALLOW_SCHEDULER -- requirements
Module: axis_allow_scheduler

---
 rtl/axis_allow_scheduler.sv | 177 +++++++++++++++++
 tb/tb_axis_allow_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_allow_scheduler.sv
// Allowance scheduler for a set of AXI-Stream gatekeepers.
// It grants one-cycle allow pulses round-robin, bounded by a shared
// downstream credit pool and a per-channel limit on outstanding packets.
module axis_allow_scheduler #(
    parameter int NUM_CH          = 4,
    parameter int CREDIT_BITS     = 9,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic [CREDIT_BITS-1:0] credit_init,
    input  logic                   credit_return,
    input  logic [7:0]             gap_cycles,
    input  logic [NUM_CH-1:0]      req,
    input  logic [NUM_CH-1:0]      pkt_done,
    output logic [NUM_CH-1:0]      allow,
    output logic [CREDIT_BITS-1:0] credits,
    output logic                   busy,
    output logic                   err_underflow
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int OUT_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t                   state_q, state_d;
    logic [CREDIT_BITS-1:0]   credits_q, credits_d;
    logic [OUT_W-1:0]         outstanding_q [NUM_CH];
    logic [OUT_W-1:0]         outstanding_d [NUM_CH];
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         winner_q, winner_d;
    logic [7:0]               gap_cnt_q, gap_cnt_d;
    logic                     err_q, err_d;

    logic [NUM_CH-1:0]        eligible;
    logic                     arb_found;
    logic [PTR_W-1:0]         arb_idx;
    logic                     grant_now;

    assign grant_now = (state_q == ST_GRANT);

    // Round-robin pick: first eligible channel at or above rr_ptr, else wrap to the lowest.
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        eligible  = '0;
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = req[i] && (outstanding_q[i] < OUT_W'(MAX_OUTSTANDING));
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!arb_found && eligible[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                arb_found = 1'b1;
                arb_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!arb_found && eligible[i]) begin
                arb_found = 1'b1;
                arb_idx   = PTR_W'(i);
            end
        end
    end

    // FSM next state, registered winner, round-robin pointer and gap counter.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        rr_ptr_d  = rr_ptr_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_LOAD: state_d = ST_IDLE;
            ST_IDLE: begin
                if (enable && (credits_q != '0) && arb_found) begin
                    state_d  = ST_GRANT;
                    winner_d = arb_idx;
                end
            end
            ST_GRANT: begin
                rr_ptr_d = (winner_q == PTR_W'(NUM_CH - 1)) ? '0 : winner_q + PTR_W'(1);
                if (gap_cycles != 8'd0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = gap_cycles;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
                if (gap_cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Credit pool: load, grant consumes one, return adds one (saturating); both together cancel.
    always_comb begin
        credits_d = credits_q;
        if (state_q == ST_LOAD) begin
            credits_d = credit_init;
        end else if (grant_now && !credit_return) begin
            credits_d = credits_q - CREDIT_BITS'(1);
        end else if (!grant_now && credit_return && (credits_q != '1)) begin
            credits_d = credits_q + CREDIT_BITS'(1);
        end
    end

    // Per-channel outstanding counts; a done with nothing outstanding raises the sticky error.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_CH; i++) begin
            outstanding_d[i] = outstanding_q[i];
            if (grant_now && (winner_q == PTR_W'(i))) begin
                if (!pkt_done[i]) begin
                    outstanding_d[i] = outstanding_q[i] + OUT_W'(1);
                end
            end else if (pkt_done[i]) begin
                if (outstanding_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    outstanding_d[i] = outstanding_q[i] - OUT_W'(1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_LOAD;
            credits_q <= '0;
            rr_ptr_q  <= '0;
            winner_q  <= '0;
            gap_cnt_q <= '0;
            err_q     <= 1'b0;
            // NOTE: the outstanding array is small register storage that must start at zero, so it is reset explicitly.
            for (int i = 0; i < NUM_CH; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            rr_ptr_q  <= rr_ptr_d;
            winner_q  <= winner_d;
            gap_cnt_q <= gap_cnt_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                outstanding_q[i] <= outstanding_d[i];
            end
        end
    end

    // Allow pulse is decoded from the registered winner, only in GRANT.
    always_comb begin
        allow = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            allow[i] = grant_now && (winner_q == PTR_W'(i));
        end
    end

    assign credits       = credits_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_underflow = err_q;

endmodule

// File: tb/tb_axis_allow_scheduler.sv
// Self-checking bench for axis_allow_scheduler: a transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_axis_allow_scheduler;

    localparam int N    = 4;
    localparam int CB   = 9;
    localparam int MAXO = 8;
    localparam int CMAX = (1 << CB) - 1;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          enable;
    logic [CB-1:0] credit_init;
    logic          credit_return;
    logic [7:0]    gap_cycles;
    logic [N-1:0]  req;
    logic [N-1:0]  pkt_done;
    logic [N-1:0]  allow;
    logic [CB-1:0] credits;
    logic          busy;
    logic          err_underflow;

    axis_allow_scheduler #(
        .NUM_CH(N),
        .CREDIT_BITS(CB),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .enable(enable),
        .credit_init(credit_init),
        .credit_return(credit_return),
        .gap_cycles(gap_cycles),
        .req(req),
        .pkt_done(pkt_done),
        .allow(allow),
        .credits(credits),
        .busy(busy),
        .err_underflow(err_underflow)
    );

    always #5 aclk = ~aclk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The scheduler is seen as: a load cycle, then idle slots where a grant may be
    // chosen, a grant cycle for the chosen channel, and a cool-down of gap_cycles.
    bit model_valid = 1'b0;
    bit m_loading;
    int m_grant;      // channel being granted this cycle, -1 if none
    int m_wait;       // cool-down cycles still to run
    int m_rr;
    int m_credits;
    int m_out [N];
    bit m_err;

    always @(posedge aclk) begin
        int  g;
        int  pick;
        bit  was_loading;
        int  old_out [N];
        if (!aresetn) begin
            model_valid = 1'b1;
            m_loading   = 1'b1;
            m_grant     = -1;
            m_wait      = 0;
            m_rr        = 0;
            m_credits   = 0;
            m_err       = 1'b0;
            for (int i = 0; i < N; i++) m_out[i] = 0;
        end else if (model_valid) begin
            g           = m_grant;
            was_loading = m_loading;
            pick        = -1;
            for (int i = 0; i < N; i++) old_out[i] = m_out[i];
            // who (if anyone) is granted next cycle
            if (was_loading) begin
                m_loading = 1'b0;
            end else if (g >= 0) begin
                m_rr   = (g + 1) % N;
                m_wait = int'(gap_cycles);
            end else if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (enable && m_credits != 0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (pick < 0 && req[c] && old_out[c] < MAXO) pick = c;
                end
            end
            m_grant = pick;
            // credit pool
            if (was_loading) m_credits = int'(credit_init);
            else if (g >= 0 && !credit_return) m_credits = m_credits - 1;
            else if (g < 0 && credit_return && m_credits < CMAX) m_credits = m_credits + 1;
            // outstanding bookkeeping
            for (int i = 0; i < N; i++) begin
                if (g == i) begin
                    if (!pkt_done[i]) m_out[i] = old_out[i] + 1;
                end else if (pkt_done[i]) begin
                    if (old_out[i] == 0) m_err = 1'b1;
                    else m_out[i] = old_out[i] - 1;
                end
            end
        end
    end

    // compare DUT against model every cycle, away from the rising edge
    always @(negedge aclk) begin
        if (model_valid) begin
            check("allow",  32'(allow),  (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
            check("credits", 32'(credits), 32'(m_credits));
            check("busy",    32'(busy),  32'(m_loading || m_grant >= 0 || m_wait > 0));
            check("err",     32'(err_underflow), 32'(m_err));
        end
    end

    // grant log for directed expectations
    int cyc = 0;
    int g_cycle[$];
    int g_ch[$];
    always @(posedge aclk) cyc++;
    always @(negedge aclk) begin
        if (model_valid && allow != '0) begin
            for (int i = 0; i < N; i++) begin
                if (allow[i]) begin
                    g_cycle.push_back(cyc);
                    g_ch.push_back(i);
                end
            end
        end
    end

    task automatic clear_log();
        g_cycle.delete();
        g_ch.delete();
    endtask

    task automatic do_reset(input int init);
        @(negedge aclk);
        aresetn       = 1'b0;
        enable        = 1'b0;
        credit_return = 1'b0;
        req           = '0;
        pkt_done      = '0;
        credit_init   = CB'(init);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        clear_log();
    endtask

    task automatic wait_allow(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge aclk);
            if (allow != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        aresetn       = 1'b0;
        enable        = 1'b0;
        credit_init   = '0;
        credit_return = 1'b0;
        gap_cycles    = 8'd0;
        req           = '0;
        pkt_done      = '0;

        // reset state
        @(negedge aclk);
        @(negedge aclk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_allow", 32'(allow), 32'd0);
        check("rst_credits", 32'(credits), 32'd0);

        // three credits, no gap, all channels requesting
        gap_cycles = 8'd0;
        do_reset(3);
        req    = 4'b1111;
        enable = 1'b1;
        repeat (20) @(negedge aclk);
        check("t1_count", 32'(g_ch.size()), 32'd3);
        if (g_ch.size() == 3) begin
            check("t1_ch0", 32'(g_ch[0]), 32'd0);
            check("t1_ch1", 32'(g_ch[1]), 32'd1);
            check("t1_ch2", 32'(g_ch[2]), 32'd2);
            check("t1_sp0", 32'(g_cycle[1] - g_cycle[0]), 32'd2);
            check("t1_sp1", 32'(g_cycle[2] - g_cycle[1]), 32'd2);
        end
        check("t1_credits", 32'(credits), 32'd0);

        // gap of three, channels 0 and 2, each grant completed next cycle
        gap_cycles = 8'd3;
        do_reset(100);
        req    = 4'b0101;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            pkt_done = allow;
        end
        pkt_done = '0;
        check("t2_count_ge4", 32'(g_ch.size() >= 4), 32'd1);
        if (g_ch.size() >= 4) begin
            check("t2_ch0", 32'(g_ch[0]), 32'd0);
            check("t2_ch1", 32'(g_ch[1]), 32'd2);
            check("t2_ch2", 32'(g_ch[2]), 32'd0);
            check("t2_ch3", 32'(g_ch[3]), 32'd2);
            check("t2_sp0", 32'(g_cycle[1] - g_cycle[0]), 32'd5);
            check("t2_sp1", 32'(g_cycle[2] - g_cycle[1]), 32'd5);
            check("t2_sp2", 32'(g_cycle[3] - g_cycle[2]), 32'd5);
        end
        check("t2_err", 32'(err_underflow), 32'd0);

        // outstanding limit on a single channel
        gap_cycles = 8'd0;
        do_reset(20);
        req    = 4'b0001;
        enable = 1'b1;
        repeat (30) @(negedge aclk);
        check("t3_limit", 32'(g_ch.size()), 32'd8);
        pkt_done = 4'b0001;
        @(negedge aclk);
        pkt_done = '0;
        repeat (20) @(negedge aclk);
        check("t3_one_more", 32'(g_ch.size()), 32'd9);
        check("t3_credits", 32'(credits), 32'd11);

        // return coincident with grant, return alone, saturation
        do_reset(5);
        req    = 4'b0001;
        enable = 1'b1;
        wait_allow("t4_grant_timeout");
        enable        = 1'b0;
        credit_return = 1'b1;
        @(negedge aclk);
        check("t4_coincident", 32'(credits), 32'd5);
        @(negedge aclk);
        credit_return = 1'b0;
        check("t4_return", 32'(credits), 32'd6);
        do_reset(CMAX);
        credit_return = 1'b1;
        repeat (3) @(negedge aclk);
        credit_return = 1'b0;
        check("t4_saturate", 32'(credits), 32'(CMAX));

        // underflow on channel 1 is sticky and does not corrupt the count
        do_reset(20);
        pkt_done = 4'b0010;
        @(negedge aclk);
        pkt_done = '0;
        check("t5_err_set", 32'(err_underflow), 32'd1);
        req    = 4'b0010;
        enable = 1'b1;
        repeat (30) @(negedge aclk);
        check("t5_err_sticky", 32'(err_underflow), 32'd1);
        check("t5_ch1_limit", 32'(g_ch.size()), 32'd8);

        // reset during gap
        gap_cycles = 8'd10;
        do_reset(8);
        pkt_done = 4'b1000;
        @(negedge aclk);
        pkt_done = '0;
        req    = 4'b0001;
        enable = 1'b1;
        wait_allow("t6_grant_timeout");
        @(negedge aclk);
        check("t6_credits_gap", 32'(credits), 32'd7);
        check("t6_busy_gap", 32'(busy), 32'd1);
        check("t6_err_before", 32'(err_underflow), 32'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        req     = 4'b1111;
        check("t6_load_allow", 32'(allow), 32'd0);
        check("t6_load_busy", 32'(busy), 32'd1);
        check("t6_load_err", 32'(err_underflow), 32'd0);
        check("t6_load_credits", 32'(credits), 32'd0);
        @(negedge aclk);
        clear_log();
        check("t6_init_credits", 32'(credits), 32'd8);
        check("t6_idle", 32'(busy), 32'd0);
        repeat (4) @(negedge aclk);
        check("t6_first_grant_seen", 32'(g_ch.size() >= 1), 32'd1);
        if (g_ch.size() >= 1) check("t6_rr_reset", 32'(g_ch[0]), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
